// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID register: owns the PC, keeps at most one instruction-memory read in flight,
// and absorbs stalls (through a one-entry skid buffer) and redirects (flushing, dropping stale reads).
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_inst_o,
  output logic [24:0] id_inst_31_7_o
);

  typedef enum logic [2:0] {S_BOOT, S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic [31:0] id_inst_reg, id_inst_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
  logic        req;
  logic        load_bubble;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    id_valid_next  = id_valid_reg;
    id_pc_next     = id_pc_reg;
    id_pc4_next    = id_pc4_reg;
    id_inst_next   = id_inst_reg;
    buf_valid_next = buf_valid_reg;
    buf_pc_next    = buf_pc_reg;
    buf_inst_next  = buf_inst_reg;
    req            = 1'b0;
    load_bubble    = redirect_i;

    // Redirect overrides stall and rvalid everywhere; only the next state differs per state.
    if (redirect_i) begin
      pc_next        = redirect_target;
      buf_valid_next = 1'b0;
    end

    case (state_reg)
      S_BOOT: state_next = S_ISSUE;

      S_ISSUE: begin
        if (!redirect_i) begin
          req         = 1'b1;
          pc_next     = pc_reg + 32'd4;
          state_next  = S_WAIT;
          load_bubble = !stall_i;
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          state_next = imem_rvalid_i ? S_ISSUE : S_DROP;
        end else if (imem_rvalid_i && !stall_i) begin
          // pc already points past the returning read, so its address is pc - 4.
          req           = 1'b1;
          id_valid_next = 1'b1;
          id_pc_next    = pc_reg - 32'd4;
          id_pc4_next   = pc_reg;
          id_inst_next  = imem_rdata_i;
          pc_next       = pc_reg + 32'd4;
        end else if (imem_rvalid_i) begin
          buf_valid_next = 1'b1;
          buf_pc_next    = pc_reg - 32'd4;
          buf_inst_next  = imem_rdata_i;
          state_next     = S_HOLD;
        end else begin
          load_bubble = !stall_i;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          state_next = S_ISSUE;
        end else if (!stall_i) begin
          id_valid_next  = buf_valid_reg;
          id_pc_next     = buf_pc_reg;
          id_pc4_next    = buf_pc_reg + 32'd4;
          id_inst_next   = buf_valid_reg ? buf_inst_reg : NOP_INST;
          buf_valid_next = 1'b0;
          state_next     = S_ISSUE;
        end
      end

      S_DROP: begin
        // A redirect arriving with the stale response still counts as that one discard.
        if (imem_rvalid_i) state_next = S_ISSUE;
        if (!redirect_i) load_bubble = !stall_i;
      end

      default: state_next = S_BOOT;
    endcase

    if (load_bubble) begin
      id_valid_next = 1'b0;
      id_inst_next  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_BOOT;
      pc_reg        <= RESET_PC;
      id_valid_reg  <= 1'b0;
      id_pc_reg     <= 32'd0;
      id_pc4_reg    <= 32'd4;
      id_inst_reg   <= NOP_INST;
      buf_valid_reg <= 1'b0;
      buf_pc_reg    <= 32'd0;
      buf_inst_reg  <= NOP_INST;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      id_valid_reg  <= id_valid_next;
      id_pc_reg     <= id_pc_next;
      id_pc4_reg    <= id_pc4_next;
      id_inst_reg   <= id_inst_next;
      buf_valid_reg <= buf_valid_next;
      buf_pc_reg    <= buf_pc_next;
      buf_inst_reg  <= buf_inst_next;
    end
  end

  assign imem_req_o     = req;
  assign imem_addr_o    = pc_reg;
  assign id_valid_o     = id_valid_reg;
  assign id_pc_o        = id_pc_reg;
  assign id_pc4_o       = id_pc4_reg;
  assign id_inst_o      = id_inst_reg;
  assign id_inst_31_7_o = id_inst_reg[31:7];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: a latency-programmable memory model plus a program-order reference
// of what ID should consume, driven by directed scenarios and a randomized stall/redirect run.
module tb_if_id_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic [31:0] id_inst_o;
  logic [24:0] id_inst_31_7_o;

  if_id_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o), .id_inst_o(id_inst_o),
    .id_inst_31_7_o(id_inst_31_7_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          consumed = 0;
  // memory model: one pending read with a countdown
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  int          lat = 1;
  bit          rand_lat = 0;
  bit          spur_en = 0;
  // program-order reference
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  bit          prev_stall = 0;
  bit          prev_redir = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_inst = 32'd0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic observe();
    logic [31:0] tgt;
    tgt = redirect_pc_i & 32'hFFFF_FFFC;
    check_val("inst_31_7", {7'd0, id_inst_31_7_o}, {7'd0, id_inst_o[31:7]});
    if (!id_valid_o) check_val("bubble_nop", id_inst_o, NOP);
    if (prev_redir) begin
      check_val("flush_valid", {31'd0, id_valid_o}, 32'd0);
    end else if (prev_stall) begin
      check_val("hold_valid", {31'd0, id_valid_o}, {31'd0, prev_valid});
      check_val("hold_pc", id_pc_o, prev_pc);
      check_val("hold_inst", id_inst_o, prev_inst);
    end
    // ID consumes the instruction when it is valid, not stalled and not killed by a redirect
    if (id_valid_o && !stall_i && !redirect_i) begin
      check_val("id_pc", id_pc_o, exp_pc);
      check_val("id_pc4", id_pc4_o, exp_pc + 32'd4);
      check_val("id_inst", id_inst_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (redirect_i) begin
      exp_pc = tgt;
      check_val("req_on_redirect", {31'd0, imem_req_o}, 32'd0);
    end
    last_req  = imem_req_o;
    last_addr = imem_addr_o;
    if (imem_req_o) begin
      check_val("fetch_addr", imem_addr_o, exp_fetch);
      check_val("outstanding", {31'd0, pend && !imem_rvalid_i}, 32'd0);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_i) exp_fetch = tgt;
    if (pend && imem_rvalid_i) pend = 0;
    if (imem_req_o) begin
      pend  = 1;
      paddr = imem_addr_o;
      cnt   = rand_lat ? int'($urandom_range(1, 4)) : lat;
    end
    prev_stall = stall_i;
    prev_redir = redirect_i;
    prev_valid = id_valid_o;
    prev_pc    = id_pc_o;
    prev_inst  = id_inst_o;
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    if (pend && cnt > 0) cnt--;
    imem_rvalid_i = pend && cnt == 0;
    imem_rdata_i  = imem_rvalid_i ? mem_word(paddr) : $urandom;
    if (!pend && spur_en && $urandom_range(0, 7) == 0) imem_rvalid_i = 1'b1;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    #1;
    check_val("rst_valid", {31'd0, id_valid_o}, 32'd0);
    check_val("rst_inst", id_inst_o, NOP);
    check_val("rst_pc", id_pc_o, 32'd0);
    check_val("rst_pc4", id_pc4_o, 32'd4);
    check_val("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_val("rst_addr", imem_addr_o, RESET_PC);
    pend = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
    prev_stall = 0; prev_redir = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // a stale response showing up during BOOT must be ignored
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check_val("boot_req", {31'd0, imem_req_o}, 32'd0);
  endtask

  initial begin
    int first, second;
    bit seen_req, seen_valid;

    // 1-cycle memory, back-to-back fetch
    do_reset();
    lat = 1;
    cycle(0, 0, 0); check_val("a_req0", {31'd0, last_req}, 32'd1); check_val("a_addr0", last_addr, 32'h0);
    cycle(0, 0, 0); check_val("a_req1", {31'd0, last_req}, 32'd1); check_val("a_addr1", last_addr, 32'h4);
    cycle(0, 0, 0);
    check_val("a_valid0", {31'd0, id_valid_o}, 32'd1);
    check_val("a_pc0", id_pc_o, 32'h0);
    check_val("a_imm0", {7'd0, id_inst_31_7_o}, 32'h0014001);
    cycle(0, 0, 0); check_val("a_pc1", id_pc_o, 32'h4);

    // 3-cycle memory: two bubbles between instructions
    do_reset();
    lat = 3; first = -1; second = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(0, 0, 0);
      if (id_valid_o) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_val("b_gap", second - first, 32'd3);

    // stall while a response arrives: skid buffer holds it
    do_reset();
    lat = 1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check_val("c_stall_pc", id_pc_o, 32'h0);
    end
    cycle(0, 0, 0);
    lat = 3;
    cycle(0, 0, 0);
    check_val("c_buf_pc", id_pc_o, 32'h4);
    check_val("c_buf_valid", {31'd0, id_valid_o}, 32'd1);
    check_val("c_resume_addr", last_addr, 32'h8);

    // redirect with an outstanding read
    cycle(0, 1, 32'h0000_0103);
    cycle(0, 0, 0);
    check_val("d_flush", {31'd0, id_valid_o}, 32'd0);
    seen_req = 0; seen_valid = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(0, 0, 0);
      if (last_req && !seen_req) begin
        seen_req = 1;
        check_val("d_addr", last_addr, 32'h100);
      end
      if (id_valid_o && !seen_valid) begin
        seen_valid = 1;
        check_val("d_pc", id_pc_o, 32'h100);
      end
    end
    check_val("d_seen", {30'd0, seen_req, seen_valid}, 32'd3);

    // redirect + stall + rvalid together
    do_reset();
    lat = 1;
    cycle(0, 0, 0);
    lat = 3;
    cycle(1, 1, 32'h0000_0300);
    cycle(0, 0, 0);
    check_val("e_valid", {31'd0, id_valid_o}, 32'd0);
    check_val("e_addr", last_addr, 32'h300);

    // reset in WAIT with pc = 0x40
    cycle(0, 1, 32'h0000_003C);
    seen_req = 0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      cycle(0, 0, 0);
      if (last_req) seen_req = 1;
    end
    check_val("f_addr", last_addr, 32'h3C);
    cycle(0, 0, 0);
    check_val("f_pc40", imem_addr_o, 32'h40);
    do_reset();
    cycle(0, 0, 0);
    check_val("f_first_req", {31'd0, last_req}, 32'd1);
    check_val("f_first_addr", last_addr, RESET_PC);

    // randomized stalls, redirects (some near the top of memory), latencies, spurious rvalid
    spur_en = 1; rand_lat = 1;
    first = consumed;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, tgt);
      if (i == 1500) do_reset();
    end
    check_val("g_progress", {31'd0, (consumed - first) > 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
